// File: rtl/truth_table_scanner.sv
// Exhaustive 4-input truth-table scanner: steps {a,b,c,d} through 0..15, captures s
// for each index and compares the resulting table against EXPECTED.
module truth_table_scanner #(
  parameter logic [15:0] EXPECTED = 16'hAC3C,
  parameter int unsigned SETTLE   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        s,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] table_bits,
  output logic [4:0]  err_count,
  output logic [3:0]  err_idx
);

  localparam int unsigned IDX_W = 4;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned ERR_W = 5;
  localparam logic [CNT_W-1:0] SETTLE_RELOAD = CNT_W'(SETTLE - 1);
  localparam logic [IDX_W-1:0] LAST_IDX      = IDX_W'(15);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   cnt;
  logic               mismatch_c;
  logic [ERR_W-1:0]   err_next_c;

  // Compare of the current capture, and the error total including it.
  assign mismatch_c = (s != EXPECTED[idx]);
  assign err_next_c = err_count + ERR_W'(mismatch_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      cnt        <= '0;
      {a, b, c, d} <= 4'h0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      table_bits <= '0;
      err_count  <= '0;
      err_idx    <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            idx          <= '0;
            cnt          <= SETTLE_RELOAD;
            {a, b, c, d} <= 4'h0;
            busy         <= 1'b1;
            done         <= 1'b0;
            pass         <= 1'b0;
            table_bits   <= '0;
            err_count    <= '0;
            err_idx      <= '0;
            state        <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt == '0) begin
            state <= ST_CAPTURE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_CAPTURE: begin
          table_bits[idx] <= s;
          err_count       <= err_next_c;
          if (mismatch_c && (err_count == '0)) begin
            err_idx <= idx;
          end
          // Index 15 is terminal; otherwise present the next vector.
          if (idx == LAST_IDX) begin
            {a, b, c, d} <= 4'h0;
            busy         <= 1'b0;
            done         <= 1'b1;
            pass         <= (err_next_c == '0);
            state        <= ST_DONE;
          end else begin
            idx          <= idx + IDX_W'(1);
            {a, b, c, d} <= idx + IDX_W'(1);
            cnt          <= SETTLE_RELOAD;
            state        <= ST_SETTLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Randomized and directed scans of truth_table_scanner (SETTLE=1 and SETTLE=3)
// against a table-level reference model.
module tb_truth_table_scanner;

  localparam logic [15:0] EXP_TABLE = 16'hAC3C;

  logic clk;
  logic rst_n;
  logic start1, start3;
  logic [15:0] mask1, mask3;
  logic s1, s3;

  logic a1, b1, c1, d1, busy1, done1, pass1;
  logic [15:0] tbl1;
  logic [4:0]  errc1;
  logic [3:0]  erri1;
  logic a3, b3, c3, d3, busy3, done3, pass3;
  logic [15:0] tbl3;
  logic [4:0]  errc3;
  logic [3:0]  erri3;

  int total;
  int bad;
  int sel;

  logic [3:0]  abcd_o;
  logic        busy_o, done_o, pass_o;
  logic [15:0] tbl_o;
  logic [4:0]  errc_o;
  logic [3:0]  erri_o;

  // Function under test is modelled as a lookup of the current mask.
  assign s1 = mask1[{a1, b1, c1, d1}];
  assign s3 = mask3[{a3, b3, c3, d3}];

  truth_table_scanner #(.EXPECTED(EXP_TABLE), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .s(s1),
    .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1), .pass(pass1),
    .table_bits(tbl1), .err_count(errc1), .err_idx(erri1)
  );

  truth_table_scanner #(.EXPECTED(EXP_TABLE), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .s(s3),
    .a(a3), .b(b3), .c(c3), .d(d3), .busy(busy3), .done(done3), .pass(pass3),
    .table_bits(tbl3), .err_count(errc3), .err_idx(erri3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    if (sel == 3) begin
      abcd_o = {a3, b3, c3, d3}; busy_o = busy3; done_o = done3; pass_o = pass3;
      tbl_o = tbl3; errc_o = errc3; erri_o = erri3;
    end else begin
      abcd_o = {a1, b1, c1, d1}; busy_o = busy1; done_o = done1; pass_o = pass1;
      tbl_o = tbl1; errc_o = errc1; erri_o = erri1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: table is the mask itself; errors are the differing bits.
  task automatic model(input logic [15:0] m, output logic [4:0] errc,
                       output logic [3:0] first, output logic ok);
    logic [15:0] diff;
    int n;
    int f;
    diff = m ^ EXP_TABLE;
    n = 0;
    f = -1;
    for (int i = 0; i < 16; i++) begin
      if (diff[i]) begin
        n++;
        if (f < 0) f = i;
      end
    end
    errc  = 5'(n);
    first = (f < 0) ? 4'd0 : 4'(f);
    ok    = (n == 0);
  endtask

  task automatic set_start(input int which, input logic v);
    if (which == 3) start3 = v; else start1 = v;
  endtask

  // One scan: pulse start, follow the vector sequence each cycle, check results.
  // poke >= 0 re-pulses start at that cycle of the scan.
  task automatic run_scan(input int which, input logic [15:0] m, input int poke, input string tag);
    int p;
    logic [4:0] e_errc;
    logic [3:0] e_first;
    logic e_ok;
    sel = which;
    p = (which == 3) ? 4 : 2;
    if (which == 3) mask3 = m; else mask1 = m;
    @(negedge clk);
    set_start(which, 1'b1);
    @(posedge clk);
    for (int n = 0; n <= 16 * p; n++) begin
      @(negedge clk);
      set_start(which, n == poke);
      if (n < 16 * p)
        check({tag, "_seq"}, 32'({busy_o, done_o, abcd_o}), 32'({1'b1, 1'b0, 4'(n / p)}));
      else
        check({tag, "_end"}, 32'({busy_o, done_o, abcd_o}), 32'({1'b0, 1'b1, 4'h0}));
    end
    model(m, e_errc, e_first, e_ok);
    check({tag, "_table"}, 32'(tbl_o), 32'(m));
    check({tag, "_errc"}, 32'(errc_o), 32'(e_errc));
    if (e_errc != 0) check({tag, "_erridx"}, 32'(erri_o), 32'(e_first));
    check({tag, "_pass"}, 32'(pass_o), 32'(e_ok));
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, 32'({abcd_o, busy_o, done_o, pass_o, tbl_o, errc_o, erri_o}), 32'd0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    sel = 1;
    rst_n = 1'b0;
    start1 = 1'b0;
    start3 = 1'b0;
    mask1 = EXP_TABLE;
    mask3 = EXP_TABLE;
    repeat (3) @(negedge clk);
    check_all_zero("reset1");
    sel = 3;
    #1 check_all_zero("reset3");
    rst_n = 1'b1;

    run_scan(1, EXP_TABLE, -1, "pos");
    run_scan(1, 16'h0000, -1, "zero");
    run_scan(1, 16'h53C3, -1, "inv");
    run_scan(1, EXP_TABLE, 10, "busy_start");
    run_scan(1, EXP_TABLE, -1, "restart");

    // Asynchronous reset while index 7 is presented.
    sel = 1;
    mask1 = EXP_TABLE;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    repeat (14) @(negedge clk);
    check("mid_idx", 32'(abcd_o), 32'd7);
    #2 rst_n = 1'b0;
    #1 check_all_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_scan(1, EXP_TABLE, -1, "after_reset");

    for (int k = 0; k < 6; k++) run_scan(1, 16'($urandom), -1, "rand1");

    run_scan(3, EXP_TABLE, -1, "settle3");
    for (int k = 0; k < 3; k++) run_scan(3, 16'($urandom), -1, "rand3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
